mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised up/down modulo counter: the next-generation free-running counter for the plotter datapath, used for step-rate division and position tracking. It adds a configurable width and modulus, direction control, enable, a prescaler, a synchronous load, wrap or saturate mode, and a registered terminal-count pulse. It sits between the motion controller, which drives direction, enable and load, and the step/position logic, which consumes `out` and `tc`.

## Interface
- `WIDTH`, 7: counter width in bits.
- `MAX`, 2**WIDTH-1: top count value. Legal range 1 ≤ MAX ≤ 2**WIDTH-1.
- `SATURATE`, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.
- `PRESCALE`, 1: number of enabled cycles per count step. Must be ≥ 1.

Ports:
- `clk` in 1: clock. Rising-edge only.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: count enable.
- `up` in 1: direction. 1 = increment, 0 = decrement.
- `load` in 1: synchronous load strobe.
- `load_val` in WIDTH: value to load.
- `out` out WIDTH: current count.
- `tc` out 1: terminal-count pulse, one cycle wide.
- `zero` out 1: high when `out` == 0 (combinational from the `out` register).

## Operation
- Priority each cycle: `reset` > `load` > count step > hold.
- Reset values: `out`=0, `tc`=0, prescaler=0, so `zero`=1.
- Load: `out` ← min(`load_val`, MAX). Load also clears the prescaler and forces `tc`=0 in the next cycle. `en` is ignored in a load cycle.
- Prescaler:
  - Counts 0..PRESCALE-1, advancing only on cycles with `en`=1 and no load.
  - A step occurs on an enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - With `en`=0 the prescaler holds its value and is not cleared.
  - With PRESCALE=1, every enabled cycle is a step.
- Step with `up`=1:
  - If `out` < MAX: `out`+1.
  - If `out` == MAX: wraps to 0 when SATURATE=0; stays at MAX when SATURATE=1.
- Step with `up`=0:
  - If `out` > 0: `out`-1.
  - If `out` == 0: wraps to MAX when SATURATE=0; stays at 0 when SATURATE=1.
- `tc`:
  - Registered. Goes high in the cycle after a step taken while `out` sat at the boundary in the step direction (MAX going up, 0 going down).
  - Rule is identical in both modes. In saturate mode, each blocked step pulses `tc` again.
  - Otherwise 0.
- `up` may change on any cycle. It is sampled only on step cycles; no state depends on its previous value.
- Arithmetic is WIDTH bits, and the MAX compare is done before the increment. When MAX < 2**WIDTH-1, `out` never takes a value above MAX.

## Timing
- `out` changes one clock after the qualifying edge: load/step sampled at edge N is visible after edge N.
- `tc` is asserted in the same cycle the wrapped or held value appears, for exactly one cycle per boundary step.
- Step rate: at most one step per PRESCALE enabled cycles. With `en` held high, steady-state rate is clk/PRESCALE.
- Reset asserted mid-count: every register returns to its reset value at the next edge, and any pending prescaler progress is discarded.
- Load and reset together: reset wins.
- Load while `en`=1 on a step cycle: load wins, and no `tc` is produced.

## Structure
- Shared header `counter_defs.vh` holds the mode constants (MODE_WRAP=0, MODE_SAT=1) and the PRESCALE/MAX legality checks. The checks are elaboration-time `initial` checks that report an error.
- One sub-module, `tick_gen`, with parameter PRESCALE:
  - Inputs: `clk`, `reset`, `en`, `clr`.
  - Output: `tick`.
  - `clr` is tied to `load`.
- `mod_counter` holds the count register, the boundary compare, the `tc` register and the load clamp.

## Test plan
- Reset, then WIDTH=7/MAX=127/SATURATE=0/PRESCALE=1, `en`=1, `up`=1 for 130 cycles:
  - `out` runs 0..127 then 0, 1, 2.
  - `tc`=1 only in the cycle where `out`=0 after 127.
  - `zero` is high at the reset and wrap points.
- MAX=9, `up`=0 from reset:
  - `out` sequence 0→9→8…→0→9.
  - `tc` pulses on each 0→9 transition.
- SATURATE=1, MAX=9, load 8, `up`=1 for 4 cycles:
  - `out` = 9, 9, 9, 9.
  - `tc` is 0 on the 8→9 step, then 1 on each of the three held steps.
- PRESCALE=4, `en` toggling 1,1,0,1,1 from reset:
  - Single increment to 1, visible after the 4th enabled cycle, which is the 5th clock.
- Load of `load_val`=200 with MAX=100 → `out`=100.
  - Load of 5 on a prescaler step cycle → `out`=5, `tc`=0, and the prescaler restarts from 0.
- Reset asserted at `out`=57 with the prescaler mid-count:
  - `out`=0, `tc`=0 at the next edge.
  - The first step after reset release occurs exactly PRESCALE enabled cycles later.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// mod_counter_pkg
//
// Shared definitions for the plotter modulo counter slice.
//   - count_mode_e   : boundary behaviour (wrap around or hold at the limit)
//   - mode_of()      : maps the integer SATURATE parameter onto count_mode_e
//   - params_legal() : elaboration-time legality check for WIDTH/MAX/PRESCALE
// ---------------------------------------------------------------------------
package mod_counter_pkg;

  // Boundary behaviour of the counter when a step would leave 0..MAX.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  // Widest counter the integer-based parameter arithmetic can describe.
  localparam int MAX_SUPPORTED_WIDTH = 31;

  // Any non-zero SATURATE value selects hold-at-boundary behaviour.
  function automatic count_mode_e mode_of(input int saturate);
    return (saturate != 0) ? MODE_SAT : MODE_WRAP;
  endfunction

  // True when the parameter set describes a counter that can actually be
  // built: a sensible width, a top count that fits in that width and is at
  // least 1, and a prescaler of at least one enabled cycle per step.
  function automatic bit params_legal(input int width,
                                      input int max_val,
                                      input int prescale);
    bit ok;
    ok = 1'b1;
    if (width < 1 || width > MAX_SUPPORTED_WIDTH) ok = 1'b0;
    else if (max_val < 1 || max_val > ((1 << width) - 1)) ok = 1'b0;
    if (prescale < 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/mod_counter_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//
// Prescaler for mod_counter. Counts enabled cycles 0..PRESCALE-1 and raises
// 'tick' on the enabled cycle where the count sits at PRESCALE-1, i.e. once
// every PRESCALE enabled cycles. With PRESCALE=1 every enabled cycle ticks.
//
// Ports:
//   clk   in  1 : rising-edge clock
//   reset in  1 : synchronous active-high reset, clears the prescale count
//   en    in  1 : count enable; the prescale count holds while en=0
//   clr   in  1 : synchronous clear (tied to the counter load strobe);
//                 suppresses the tick and restarts the count from 0
//   tick  out 1 : step request for the current cycle (combinational)
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A single-bit register is kept even for PRESCALE=1 so that one code path
  // covers every setting; there the register simply never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcount;
  logic          at_last;

  assign at_last = (pcount == LAST);

  // A tick needs an enabled, non-clear cycle at the end of the prescale
  // window. clr wins so that a load never doubles as a step.
  assign tick = en && !clr && at_last;

  // Prescale counter: reset and clr restart the window, en advances it and
  // rolls over at LAST, and a disabled cycle leaves the progress untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcount <= '0;
    end else if (clr) begin
      pcount <= '0;
    end else if (en) begin
      if (at_last) pcount <= '0;
      else         pcount <= pcount + PW'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//
// Parametrised up/down modulo counter for the plotter datapath (step-rate
// division and position tracking). Counts in 0..MAX, steps once every
// PRESCALE enabled cycles, and either wraps or holds at the boundaries.
// A registered one-cycle 'tc' pulse marks every step that was taken while
// the count sat on the boundary in the step direction.
//
// Parameters:
//   WIDTH    : counter width in bits
//   MAX      : top count value, 1 <= MAX <= 2**WIDTH-1
//   SATURATE : 0 = wrap at the boundaries, 1 = hold at the boundaries
//   PRESCALE : enabled cycles per count step, >= 1
//
// Ports:
//   clk      in  1     : rising-edge clock
//   reset    in  1     : synchronous active-high reset
//   en       in  1     : count enable
//   up       in  1     : direction, 1 = increment, 0 = decrement
//   load     in  1     : synchronous load strobe (wins over counting)
//   load_val in  WIDTH : value to load, clamped to MAX
//   out      out WIDTH : current count
//   tc       out 1     : terminal-count pulse, one cycle wide
//   zero     out 1     : high while out == 0
// ---------------------------------------------------------------------------
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam count_mode_e      MODE  = mode_of(SATURATE);

  // Refuse to elaborate a counter whose parameters make no sense rather
  // than silently building something odd.
  if (!params_legal(WIDTH, MAX, PRESCALE)) begin : g_param_check
    $error("mod_counter: illegal parameters WIDTH=%0d MAX=%0d PRESCALE=%0d",
           WIDTH, MAX, PRESCALE);
  end

  logic             tick;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] out_next;
  logic             tc_next;

  // The prescaler is cleared by load so a load always restarts the step
  // window from a full PRESCALE enabled cycles.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  // When MAX spans the whole word every load_val is already in range, so
  // the clamp compare is only built when it can actually trigger.
  if (MAX == (2**WIDTH) - 1) begin : g_full_range
    assign load_clamped = load_val;
  end else begin : g_clamp
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
  end

  // Boundary compares are made on the current count, before any increment,
  // so the WIDTH-bit arithmetic below never has to detect an overflow.
  assign at_max  = (out == MAX_V);
  assign at_zero = (out == '0);
  assign zero    = at_zero;

  // Next-state selection in priority order load > step > hold (reset is
  // applied in the register). Direction is looked at only on step cycles.
  // A step taken on the boundary is flagged with tc in either mode; the
  // mode only decides whether the count wraps or stays put.
  always_comb begin
    out_next = out;
    tc_next  = 1'b0;
    if (load) begin
      out_next = load_clamped;
    end else if (tick) begin
      if (up) begin
        if (!at_max) begin
          out_next = out + WIDTH'(1);
        end else begin
          tc_next  = 1'b1;
          out_next = (MODE == MODE_SAT) ? MAX_V : '0;
        end
      end else begin
        if (!at_zero) begin
          out_next = out - WIDTH'(1);
        end else begin
          tc_next  = 1'b1;
          out_next = (MODE == MODE_SAT) ? '0 : MAX_V;
        end
      end
    end
  end

  // Count and terminal-count registers. tc is registered so that it rises
  // together with the wrapped or held value and lasts a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      tc  <= 1'b0;
    end else begin
      out <= out_next;
      tc  <= tc_next;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_counter
//
// Four counter instances with different parameter sets share one clock:
//   0: MAX=127 wrap, PRESCALE=1   1: MAX=9 wrap, PRESCALE=1
//   2: MAX=9 saturate, PRESCALE=1 3: MAX=100 wrap, PRESCALE=4
// Each stimulus cycle drives one instance and queues the hand-derived
// response; a monitor pops the queue just after the following clock edge.
// ---------------------------------------------------------------------------
module tb_mod_counter;

  logic clk = 1'b0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  logic       rst_s  [4];
  logic       en_s   [4];
  logic       up_s   [4];
  logic       load_s [4];
  logic [6:0] lv_s   [4];
  logic [6:0] out_s  [4];
  logic       tc_s   [4];
  logic       zero_s [4];

  mod_counter #(.WIDTH(7), .MAX(127), .SATURATE(0), .PRESCALE(1)) dut_wrap127 (
    .clk(clk), .reset(rst_s[0]), .en(en_s[0]), .up(up_s[0]), .load(load_s[0]),
    .load_val(lv_s[0]), .out(out_s[0]), .tc(tc_s[0]), .zero(zero_s[0]));

  mod_counter #(.WIDTH(7), .MAX(9), .SATURATE(0), .PRESCALE(1)) dut_wrap9 (
    .clk(clk), .reset(rst_s[1]), .en(en_s[1]), .up(up_s[1]), .load(load_s[1]),
    .load_val(lv_s[1]), .out(out_s[1]), .tc(tc_s[1]), .zero(zero_s[1]));

  mod_counter #(.WIDTH(7), .MAX(9), .SATURATE(1), .PRESCALE(1)) dut_sat9 (
    .clk(clk), .reset(rst_s[2]), .en(en_s[2]), .up(up_s[2]), .load(load_s[2]),
    .load_val(lv_s[2]), .out(out_s[2]), .tc(tc_s[2]), .zero(zero_s[2]));

  mod_counter #(.WIDTH(7), .MAX(100), .SATURATE(0), .PRESCALE(4)) dut_ps4 (
    .clk(clk), .reset(rst_s[3]), .en(en_s[3]), .up(up_s[3]), .load(load_s[3]),
    .load_val(lv_s[3]), .out(out_s[3]), .tc(tc_s[3]), .zero(zero_s[3]));

  typedef struct {
    int         dut;
    logic [6:0] exp_out;
    logic       exp_tc;
    logic       exp_zero;
    string      name;
  } expect_t;

  expect_t sb[$];
  int      checks = 0;
  int      errors = 0;

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string nm, input logic [6:0] act,
                             input logic [6:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Drives one cycle of stimulus on instance d (all others idle) and queues
  // the response expected just after the next rising edge.
  task automatic applyStimulus(input int d, input logic r, input logic e,
                               input logic u, input logic l,
                               input logic [6:0] v, input logic [6:0] eo,
                               input logic et, input string nm);
    expect_t item;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rst_s[i]  = 1'b0;
      en_s[i]   = 1'b0;
      up_s[i]   = 1'b0;
      load_s[i] = 1'b0;
      lv_s[i]   = 7'd0;
    end
    rst_s[d]  = r;
    en_s[d]   = e;
    up_s[d]   = u;
    load_s[d] = l;
    lv_s[d]   = v;
    item.dut      = d;
    item.exp_out  = eo;
    item.exp_tc   = et;
    item.exp_zero = (eo == 7'd0);
    item.name     = nm;
    sb.push_back(item);
  endtask

  // Monitor: every cycle with a queued expectation is checked 1 unit after
  // the rising edge, once the registers have settled.
  initial begin
    expect_t item;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        item = sb.pop_front();
        checkOutput({item.name, " out"},  out_s[item.dut], item.exp_out);
        checkOutput({item.name, " tc"},   7'(tc_s[item.dut]), 7'(item.exp_tc));
        checkOutput({item.name, " zero"}, 7'(zero_s[item.dut]), 7'(item.exp_zero));
      end
    end
  end

  initial begin
    logic [6:0] eo;
    logic       en_pat [5];
    logic [6:0] ps_out [5];

    for (int i = 0; i < 4; i++) begin
      rst_s[i] = 1'b0; en_s[i] = 1'b0; up_s[i] = 1'b0;
      load_s[i] = 1'b0; lv_s[i] = 7'd0;
    end

    // Instance 0: full-range up count, wrap 127 -> 0 with a single tc.
    applyStimulus(0, 1, 0, 0, 0, 7'd0, 7'd0, 1'b0, "wrap127 reset");
    for (int k = 1; k <= 130; k++) begin
      eo = 7'(k % 128);
      applyStimulus(0, 0, 1, 1, 0, 7'd0, eo, (k == 128),
                    $sformatf("wrap127 step %0d", k));
    end

    // Instance 1: down count from reset, 0 -> 9 wraps pulse tc.
    applyStimulus(1, 1, 0, 0, 0, 7'd0, 7'd0, 1'b0, "down9 reset");
    for (int k = 1; k <= 12; k++) begin
      eo = 7'((10 - (k % 10)) % 10);
      applyStimulus(1, 0, 1, 0, 0, 7'd0, eo, ((k % 10) == 1),
                    $sformatf("down9 step %0d", k));
    end

    // Instance 2: saturate at both ends; each blocked step pulses tc.
    applyStimulus(2, 1, 0, 0, 0, 7'd0, 7'd0, 1'b0, "sat9 reset");
    applyStimulus(2, 0, 1, 0, 0, 7'd0, 7'd0, 1'b1, "sat9 hold0 a");
    applyStimulus(2, 0, 1, 0, 0, 7'd0, 7'd0, 1'b1, "sat9 hold0 b");
    applyStimulus(2, 0, 0, 0, 1, 7'd8, 7'd8, 1'b0, "sat9 load8");
    applyStimulus(2, 0, 1, 1, 0, 7'd0, 7'd9, 1'b0, "sat9 up 8to9");
    for (int k = 1; k <= 3; k++)
      applyStimulus(2, 0, 1, 1, 0, 7'd0, 7'd9, 1'b1,
                    $sformatf("sat9 held %0d", k));
    applyStimulus(2, 0, 1, 1, 1, 7'd120, 7'd9, 1'b0, "sat9 load clamp");

    // Instance 3: prescaler with en gaps, first step on the 5th clock.
    en_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ps_out = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd1};
    applyStimulus(3, 1, 0, 0, 0, 7'd0, 7'd0, 1'b0, "ps4 reset");
    for (int k = 0; k < 5; k++)
      applyStimulus(3, 0, en_pat[k], 1, 0, 7'd0, ps_out[k], 1'b0,
                    $sformatf("ps4 en cycle %0d", k));

    // Load clamp, then a load on a boundary step cycle: load wins, no tc,
    // and the prescaler restarts so the next step needs 4 enabled cycles.
    applyStimulus(3, 0, 0, 1, 1, 7'd120, 7'd100, 1'b0, "ps4 load clamp");
    for (int k = 0; k < 3; k++)
      applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd100, 1'b0,
                    $sformatf("ps4 at max %0d", k));
    applyStimulus(3, 0, 1, 1, 1, 7'd5, 7'd5, 1'b0, "ps4 load on step");
    for (int k = 0; k < 3; k++)
      applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd5, 1'b0,
                    $sformatf("ps4 restart %0d", k));
    applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd6, 1'b0, "ps4 step to 6");

    // Wrap at MAX=100 with prescaling; tc lasts a single cycle.
    applyStimulus(3, 0, 0, 1, 1, 7'd100, 7'd100, 1'b0, "ps4 load100");
    for (int k = 0; k < 3; k++)
      applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd100, 1'b0,
                    $sformatf("ps4 pre wrap %0d", k));
    applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd0, 1'b1, "ps4 wrap");
    applyStimulus(3, 0, 0, 1, 0, 7'd0, 7'd0, 1'b0, "ps4 tc drop");

    // Reset mid-count at 57 discards prescaler progress.
    applyStimulus(3, 0, 0, 1, 1, 7'd57, 7'd57, 1'b0, "ps4 load57");
    applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd57, 1'b0, "ps4 mid a");
    applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd57, 1'b0, "ps4 mid b");
    applyStimulus(3, 1, 1, 1, 0, 7'd0, 7'd0, 1'b0, "ps4 reset mid");
    for (int k = 0; k < 3; k++)
      applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd0, 1'b0,
                    $sformatf("ps4 after reset %0d", k));
    applyStimulus(3, 0, 1, 1, 0, 7'd0, 7'd1, 1'b0, "ps4 first step");
    applyStimulus(3, 1, 1, 1, 1, 7'd33, 7'd0, 1'b0, "ps4 reset vs load");

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
